// File: rtl/my_sub_serial.sv
// my_sub_serial: bit-serial subtractor computing A - B, one bit per clock, LSB first.
// The difference is formed as A + ~B + 1: the carry register is seeded with 1 and
// every SHIFT cycle adds one bit of A to the inverted bit of B.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset
//   start      - request to compute A - B (accepted only in IDLE)
//   A, B       - LENGTH-bit minuend / subtrahend
//   busy       - high exactly while in SHIFT
//   done       - one-cycle completion pulse (high exactly while in DONE)
//   Result     - difference sign-extended from bit LENGTH-1 to 8 bits
//   f_carry    - carry out of bit LENGTH-1 (1 = no borrow)
//   f_overflow - signed overflow (carry into MSB xor carry out of MSB)
//   f_negativo - Result[LENGTH-1]
//   f_zero     - Result is all zero
module my_sub_serial #(
  parameter int unsigned LENGTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LENGTH-1:0] A,
  input  logic [LENGTH-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [7:0]        Result,
  output logic              f_carry,
  output logic              f_overflow,
  output logic              f_negativo,
  output logic              f_zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] LastBit = 3'(LENGTH - 1);

  logic [1:0]        state_q, state_d;
  // a_q doubles as the result register: each cycle consumes a_q[0] and the new
  // sum bit enters at the MSB, so after LENGTH shifts it holds the difference.
  logic [LENGTH-1:0] a_q, a_d;
  logic [LENGTH-1:0] b_q, b_d;
  logic              carry_q, carry_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        result_q, result_d;
  logic              carry_flag_q, carry_flag_d;
  logic              ovf_q, ovf_d;
  logic              neg_q, neg_d;
  logic              zero_q, zero_d;

  logic              a_bit;
  logic              nb_bit;
  logic              sum_bit;
  logic              carry_out;
  logic [LENGTH-1:0] diff;
  logic [7:0]        diff_ext;

  // One full-adder slice on the current bit pair.
  always_comb begin
    a_bit     = a_q[0];
    nb_bit    = ~b_q[0];
    sum_bit   = a_bit ^ nb_bit ^ carry_q;
    carry_out = (a_bit & nb_bit) | (a_bit & carry_q) | (nb_bit & carry_q);
    diff      = {sum_bit, a_q[LENGTH-1:1]};
  end

  // Sign extension written as a loop so LENGTH = 8 needs no zero-width replication.
  always_comb begin
    diff_ext = '0;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = (i < int'(LENGTH)) ? i : int'(LENGTH) - 1;
      diff_ext[i] = diff[idx];
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    carry_flag_d = carry_flag_q;
    ovf_d        = ovf_q;
    neg_d        = neg_q;
    zero_d       = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = diff;
        b_d     = b_q >> 1;
        carry_d = carry_out;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == LastBit) begin
          state_d      = DONE;
          result_d     = diff_ext;
          carry_flag_d = carry_out;
          // carry_q here is the carry into the MSB.
          ovf_d        = carry_q ^ carry_out;
          neg_d        = sum_bit;
          zero_d       = (diff_ext == 8'h00);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      result_q     <= '0;
      carry_flag_q <= 1'b0;
      ovf_q        <= 1'b0;
      neg_q        <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      carry_flag_q <= carry_flag_d;
      ovf_q        <= ovf_d;
      neg_q        <= neg_d;
      zero_q       <= zero_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign Result     = result_q;
  assign f_carry    = carry_flag_q;
  assign f_overflow = ovf_q;
  assign f_negativo = neg_q;
  assign f_zero     = zero_q;

endmodule

// File: tb/tb_my_sub_serial.sv
// Directed bench for my_sub_serial with LENGTH = 5. Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_my_sub_serial;

  localparam int unsigned L = 5;

  logic         clk;
  logic         rst;
  logic         start;
  logic [L-1:0] A;
  logic [L-1:0] B;
  logic         busy;
  logic         done;
  logic [7:0]   Result;
  logic         f_carry;
  logic         f_overflow;
  logic         f_negativo;
  logic         f_zero;

  int n_checks;
  int n_fail;

  my_sub_serial #(.LENGTH(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .Result     (Result),
    .f_carry    (f_carry),
    .f_overflow (f_overflow),
    .f_negativo (f_negativo),
    .f_zero     (f_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE. Reports busy cycle count, whether done was seen
  // within the bound, whether Result moved while busy, and the outputs in DONE.
  task automatic do_op(input logic [L-1:0] a, input logic [L-1:0] b,
                       output int busy_cnt, output logic seen,
                       output logic moved, output logic [11:0] obs);
    logic [7:0] prev;
    busy_cnt = 0;
    seen     = 1'b0;
    moved    = 1'b0;
    obs      = '0;
    prev     = Result;
    A = a;
    B = b;
    start = 1'b1;
    step();
    start = 1'b0;
    A = ~a;
    B = ~b;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        obs  = {Result, f_carry, f_overflow, f_negativo, f_zero};
        break;
      end
      if (busy) busy_cnt++;
      if (Result !== prev) moved = 1'b1;
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    A = 5'd7;
    B = 5'd3;
    step();
    step();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/done got %b expected 00", {busy, done});
    end
    n_checks++;
    if ({Result, f_carry, f_overflow, f_negativo, f_zero} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_out: result/flags got %h expected 000",
               {Result, f_carry, f_overflow, f_negativo, f_zero});
    end
    rst = 1'b0;
    start = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_sub(input string name, input logic [L-1:0] a, input logic [L-1:0] b,
                          input logic [11:0] exp);
    int bc;
    logic seen, moved;
    logic [11:0] obs;
    do_op(a, b, bc, seen, moved, obs);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done: no done pulse within bound", name);
    end
    n_checks++;
    if (bc != int'(L)) begin
      n_fail++;
      $display("FAIL %s_busy: busy cycles got %0d expected %0d", name, bc, L);
    end
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s_result: {Result,c,v,n,z} got %h expected %h", name, obs, exp);
    end
    n_checks++;
    if (moved) begin
      n_fail++;
      $display("FAIL %s_hold: Result changed during SHIFT (got 1 expected 0)", name);
    end
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_after: busy/done got %b expected 00", name, {busy, done});
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int d_cyc[2];
    logic [11:0] d_obs[2];
    int nd;
    nd = 0;
    d_cyc[0] = 0;
    d_cyc[1] = 0;
    d_obs[0] = '0;
    d_obs[1] = '0;
    A = 5'd7;
    B = 5'd3;
    start = 1'b1;
    step();
    for (cyc = 0; cyc < 30; cyc++) begin
      if (done) begin
        if (nd < 2) begin
          d_cyc[nd] = cyc;
          d_obs[nd] = {Result, f_carry, f_overflow, f_negativo, f_zero};
        end
        nd++;
        A = 5'd3;
        B = 5'd7;
        if (nd >= 2) start = 1'b0;
      end else if (busy) begin
        A = 5'($urandom);
        B = 5'($urandom);
      end
      step();
    end
    start = 1'b0;
    n_checks++;
    if (nd != 2) begin
      n_fail++;
      $display("FAIL b2b_count: done pulses got %0d expected 2", nd);
    end
    n_checks++;
    if (d_cyc[1] - d_cyc[0] != 7) begin
      n_fail++;
      $display("FAIL b2b_period: spacing got %0d expected 7", d_cyc[1] - d_cyc[0]);
    end
    n_checks++;
    if (d_obs[0] !== 12'h048) begin
      n_fail++;
      $display("FAIL b2b_first: got %h expected 048", d_obs[0]);
    end
    n_checks++;
    if (d_obs[1] !== 12'hFC2) begin
      n_fail++;
      $display("FAIL b2b_second: got %h expected fc2", d_obs[1]);
    end
  endtask

  task automatic test_abort();
    logic seen_done;
    A = 5'd15;
    B = 5'd16;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, Result, f_carry, f_overflow, f_negativo, f_zero} !== 14'h0) begin
      n_fail++;
      $display("FAIL abort_clear: {busy,done,Result,flags} got %h expected 0",
               {busy, done, Result, f_carry, f_overflow, f_negativo, f_zero});
    end
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) seen_done = 1'b1;
      step();
    end
    n_checks++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL abort_quiet: activity after abort got 1 expected 0");
    end
    test_sub("after_abort", 5'd7, 5'd3, 12'h048);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    test_reset();
    test_sub("sub_7_3",   5'd7,       5'd3,       12'h048);
    test_sub("sub_3_7",   5'd3,       5'd7,       12'hFC2);
    test_sub("sub_10_10", 5'd10,      5'd10,      12'h009);
    test_sub("sub_ovf",   5'b01111,   5'b10000,   12'hFF6);
    test_sub("sub_negov", 5'b10000,   5'b00001,   12'h0FC);
    test_sub("sub_0_0",   5'd0,       5'd0,       12'h009);
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
